// File: rtl/fir_tdm_sched.sv
// fir_tdm_sched: shares one 2-channel FIR interpolator between the left and
// right audio channels. Stereo pairs are queued and sent to the FIR as
// two-beat frames (left = sop, right = eop). The FIR result beats are
// reassembled into a stereo output pair.
// Optional build macro FIR_TDM_WATCHDOG_EN adds a watchdog that recovers the
// collector when the FIR stops answering.
//
// state  | meaning
// IDLE   | waiting for a queued pair; pops the head into the holding regs
// SEND_L | drives the left beat (sop)
// SEND_R | drives the right beat (eop)
// GAP    | forced idle beats between frames
module fir_tdm_sched #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic             AMCLK_i,
  input  logic             nARST,
  input  logic [IN_W-1:0]  in_left_i,
  input  logic [IN_W-1:0]  in_right_i,
  input  logic             in_valid_i,
  output logic [IN_W-1:0]  fir_sink_data_o,
  output logic             fir_sink_valid_o,
  output logic             fir_sink_sop_o,
  output logic             fir_sink_eop_o,
  input  logic [OUT_W-1:0] fir_source_data_i,
  input  logic             fir_source_valid_i,
  input  logic             fir_source_sop_i,
  input  logic             fir_source_eop_i,
  output logic [OUT_W-1:0] out_left_o,
  output logic [OUT_W-1:0] out_right_o,
  output logic             out_valid_o,
  output logic             ovf_o,
  output logic             err_o,
  output logic             wdog_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_L, SEND_R, GAP} state_t;

  state_t state;

  logic [IN_W-1:0] mem_left  [FIFO_DEPTH];
  logic [IN_W-1:0] mem_right [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;

  logic [IN_W-1:0] hold_left;
  logic [IN_W-1:0] hold_right;
  logic [GW-1:0]   gap_cnt;

  logic [OUT_W-1:0] left_hold;
  logic             have_left;
  logic [2:0]       outstanding;

  logic beat_l;
  logic beat_r;
  logic beat_both;
  logic complete;
  logic inc_out;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;
  // A full queue still accepts a pair when the FSM pops in the same cycle.
  assign push  = in_valid_i && (!full || pop);
  assign drop  = in_valid_i && full && !pop;

  assign beat_l    = fir_source_valid_i &&  fir_source_sop_i && !fir_source_eop_i;
  assign beat_r    = fir_source_valid_i && !fir_source_sop_i &&  fir_source_eop_i;
  assign beat_both = fir_source_valid_i &&  fir_source_sop_i &&  fir_source_eop_i;
  assign complete  = beat_r && have_left;
  assign inc_out   = (state == SEND_L);

  // Queue storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge AMCLK_i) begin
    if (push) begin
      mem_left[wr_ptr]  <= in_left_i;
      mem_right[wr_ptr] <= in_right_i;
    end
  end

  // Queue pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) ovf_o <= 1'b1;
    end
  end

  // Frame issue FSM with registered sink outputs.
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      state            <= IDLE;
      hold_left        <= '0;
      hold_right       <= '0;
      gap_cnt          <= '0;
      fir_sink_data_o  <= '0;
      fir_sink_valid_o <= 1'b0;
      fir_sink_sop_o   <= 1'b0;
      fir_sink_eop_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fir_sink_valid_o <= 1'b0;
          fir_sink_sop_o   <= 1'b0;
          fir_sink_eop_o   <= 1'b0;
          if (pop) begin
            hold_left  <= mem_left[rd_ptr];
            hold_right <= mem_right[rd_ptr];
            state      <= SEND_L;
          end
        end
        SEND_L: begin
          fir_sink_data_o  <= hold_left;
          fir_sink_valid_o <= 1'b1;
          fir_sink_sop_o   <= 1'b1;
          fir_sink_eop_o   <= 1'b0;
          state            <= SEND_R;
        end
        SEND_R: begin
          fir_sink_data_o  <= hold_right;
          fir_sink_valid_o <= 1'b1;
          fir_sink_sop_o   <= 1'b0;
          fir_sink_eop_o   <= 1'b1;
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GW'(GAP_CYCLES - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          fir_sink_valid_o <= 1'b0;
          fir_sink_sop_o   <= 1'b0;
          fir_sink_eop_o   <= 1'b0;
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_TDM_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_fire;

  assign wdog_fire = (outstanding != 3'd0) && !fir_source_valid_i &&
                     (wdog_cnt == 16'(TIMEOUT));
`endif

  // Result collector: pairs a left beat with the following right beat and
  // tracks frames sent to the FIR that have not come back yet.
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      left_hold   <= '0;
      have_left   <= 1'b0;
      outstanding <= 3'd0;
      out_left_o  <= '0;
      out_right_o <= '0;
      out_valid_o <= 1'b0;
      err_o       <= 1'b0;
`ifdef FIR_TDM_WATCHDOG_EN
      wdog_cnt    <= '0;
      wdog_o      <= 1'b0;
`endif
    end else begin
      out_valid_o <= 1'b0;
      if (beat_l) begin
        left_hold <= fir_source_data_i;
        have_left <= 1'b1;
        if (have_left) err_o <= 1'b1;
      end
      if (complete) begin
        out_left_o  <= left_hold;
        out_right_o <= fir_source_data_i;
        out_valid_o <= 1'b1;
        have_left   <= 1'b0;
      end
      if ((beat_r && !have_left) || beat_both) err_o <= 1'b1;
      case ({inc_out, complete})
        2'b10:   if (outstanding != 3'd7) outstanding <= outstanding + 3'd1;
        2'b01:   if (outstanding != 3'd0) outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
`ifdef FIR_TDM_WATCHDOG_EN
      // Recovery overrides any collector update made above in this cycle.
      wdog_o <= 1'b0;
      if (wdog_fire) begin
        have_left   <= 1'b0;
        outstanding <= 3'd0;
        wdog_cnt    <= '0;
        wdog_o      <= 1'b1;
      end else if (fir_source_valid_i) begin
        wdog_cnt <= '0;
      end else if (outstanding != 3'd0) begin
        wdog_cnt <= wdog_cnt + 16'd1;
      end
`endif
    end
  end

`ifndef FIR_TDM_WATCHDOG_EN
  // No watchdog in this build; the limit only matters when it is present.
  assign wdog_o = 1'b0 && (TIMEOUT > 0);
`endif

endmodule
